// File: rtl/round_key_store.sv
// AES-128 round key expansion controller and 11 x 128-bit round key store with a registered read port.
// Optional ROUND_KEY_STORE_ZEROIZE_EN adds a zeroize input that wipes the store and aborts expansion.
module round_key_store #(
    parameter int KS_LATENCY = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         done,
    output logic         ks_load,
    output logic [0:127] ks_keyin,
    output logic [0:3]   ks_round_no,
    input  logic [0:127] ks_keyout,
    input  logic         rd_en,
    input  logic [0:3]   rd_addr,
    output logic [0:127] rd_key,
    output logic         rd_valid
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    ,
    input  logic         zeroize
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [3:0] LAT_LAST  = 4'(KS_LATENCY - 1);
    localparam logic [3:0] LAST_ROUND = 4'd9;

    logic [2:0]   state;
    logic [3:0]   round_q;
    logic [3:0]   wait_cnt;
    logic [3:0]   valid_cnt;
    logic [0:127] keys [0:10];

    assign busy = (state == LOAD) || (state == WAIT) || (state == CAPTURE);
    assign done = (state == DONE);

    // ks_* are only updated on the edge that enters LOAD, so they stay stable through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            round_q     <= 4'd0;
            wait_cnt    <= 4'd0;
            valid_cnt   <= 4'd0;
            ks_load     <= 1'b0;
            ks_keyin    <= '0;
            ks_round_no <= 4'd0;
            for (int i = 0; i < 11; i++) keys[i] <= '0;
        end
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
        else if (zeroize) begin
            state     <= IDLE;
            round_q   <= 4'd0;
            wait_cnt  <= 4'd0;
            valid_cnt <= 4'd0;
            ks_load   <= 1'b0;
            for (int i = 0; i < 11; i++) keys[i] <= '0;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        keys[0]     <= key_in;
                        valid_cnt   <= 4'd1;
                        round_q     <= 4'd0;
                        ks_load     <= 1'b1;
                        ks_keyin    <= key_in;
                        ks_round_no <= 4'd0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    ks_load  <= 1'b0;
                    wait_cnt <= 4'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == LAT_LAST) state <= CAPTURE;
                    else                      wait_cnt <= wait_cnt + 4'd1;
                end
                CAPTURE: begin
                    keys[round_q + 4'd1] <= ks_keyout;
                    valid_cnt            <= valid_cnt + 4'd1;
                    if (round_q == LAST_ROUND) begin
                        state <= DONE;
                    end else begin
                        round_q     <= round_q + 4'd1;
                        ks_load     <= 1'b1;
                        ks_keyin    <= ks_keyout;
                        ks_round_no <= round_q + 4'd1;
                        state       <= LOAD;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read sees the pre-edge store and valid count, so a same-cycle write returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            if (rd_addr < valid_cnt) begin
                rd_key   <= keys[rd_addr];
                rd_valid <= 1'b1;
            end else begin
                rd_key   <= '0;
                rd_valid <= 1'b0;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// Scoreboard bench for round_key_store: AES key expansion reference, behavioural key_schedule,
// randomized reads checked by a decoupled monitor. Define ROUND_KEY_STORE_ZEROIZE_EN to cover zeroize.
module tb_round_key_store;

    localparam int L = 8;
    localparam int P = L + 2;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [0:127] key_in = '0;
    logic         busy;
    logic         done;
    logic         ks_load;
    logic [0:127] ks_keyin;
    logic [0:3]   ks_round_no;
    logic [0:127] ks_keyout = '0;
    logic         rd_en = 1'b0;
    logic [0:3]   rd_addr = '0;
    logic [0:127] rd_key;
    logic         rd_valid;
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    round_key_store #(.KS_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .ks_load(ks_load), .ks_keyin(ks_keyin),
        .ks_round_no(ks_round_no), .ks_keyout(ks_keyout),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_key(rd_key), .rd_valid(rd_valid)
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
        , .zeroize(zeroize)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int t0 = 0;
    bit run_active = 1'b0;
    logic [127:0] model_keys [0:10];

    typedef struct { logic v; logic [127:0] k; } rd_exp_t;
    rd_exp_t rd_q[$];
    int      done_q[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // AES arithmetic for the reference key expansion
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [15:0] d;
        d = {x, x} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq = a; inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < r; i++) rc = xt(rc);
        return rc;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic expand(input logic [127:0] k);
        model_keys[0] = k;
        for (int r = 0; r < 10; r++) model_keys[r + 1] = next_key(model_keys[r], rcon(r));
    endtask

    // Behavioural key_schedule: result appears L cycles after ks_load falls, zero before that
    int           ksm_cnt = L;
    logic [127:0] ksm_in = '0;
    logic [3:0]   ksm_rn = '0;
    always @(posedge clk) begin
        if (ks_load) begin
            ksm_in    <= ks_keyin;
            ksm_rn    <= ks_round_no;
            ksm_cnt   <= 0;
            ks_keyout <= '0;
        end else if (ksm_cnt < L) begin
            ksm_cnt <= ksm_cnt + 1;
            if (ksm_cnt == L - 1) ks_keyout <= next_key(ksm_in, rcon(int'(ksm_rn)));
        end
    end

    // Keys stored so far, as seen by a read sampled at the end of absolute cycle n_abs
    function automatic int exp_count(input int n_abs);
        int n, c;
        if (!run_active) return 0;
        n = n_abs - t0;
        c = 1;
        for (int k = 1; k <= 10; k++) if (k * P < n) c++;
        return c;
    endfunction

    // Monitor
    logic         rd_seen = 1'b0;
    logic [127:0] last_key = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_seen <= 1'b0;
        else        rd_seen <= rd_en;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            last_key = '0;
        end else begin
            int n, r;
            bit eb, el;
            rd_exp_t e;
            if (rd_seen) begin
                if (rd_q.size() == 0) check("rd_queue_nonempty", 128'(rd_q.size()), 128'(1));
                else begin
                    e = rd_q.pop_front();
                    check("rd_valid", 128'(rd_valid), 128'(e.v));
                    check("rd_key", rd_key, e.k);
                end
            end else begin
                check("rd_valid_idle", 128'(rd_valid), 128'(0));
                check("rd_key_hold", rd_key, last_key);
            end
            last_key = rd_key;
            if (done) begin
                if (done_q.size() == 0) check("done_expected", 128'(done_q.size()), 128'(1));
                else check("done_cycle", 128'(edge_cnt), 128'(done_q.pop_front()));
            end
            n  = edge_cnt - t0;
            eb = run_active && n >= 1 && n <= 10 * P;
            el = eb && ((n - 1) % P == 0);
            check("busy", 128'(busy), 128'(eb));
            check("ks_load", 128'(ks_load), 128'(el));
            if (el) begin
                r = (n - 1) / P;
                check("ks_round_no", 128'(ks_round_no), 128'(r));
                check("ks_keyin", ks_keyin, model_keys[r]);
            end
        end
    end

    // Driver
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (edge_cnt < t0 + c) step();
    endtask

    task automatic do_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        if (!run_active || (edge_cnt - t0) >= 10 * P + 2) begin
            t0 = edge_cnt;
            run_active = 1'b1;
            expand(k);
            done_q.push_back(t0 + 10 * P + 1);
        end
        step();
        start = 1'b0;
    endtask

    task automatic issue_read(input int a, input bit fixed, input logic [127:0] fk);
        rd_exp_t e;
        int c;
        rd_en   = 1'b1;
        rd_addr = 4'(a);
        c = exp_count(edge_cnt);
        e.v = (a < c);
        e.k = (a < c) ? (fixed ? fk : model_keys[a]) : 128'h0;
        rd_q.push_back(e);
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_read(input int a);
        issue_read(a, 1'b0, 128'h0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && done_q.size() != 0; i++) step();
        if (done_q.size() != 0) begin
            check("done_timeout", 128'(done_q.size()), 128'(0));
            done_q.delete();
        end
        step();
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_ks_load"}, 128'(ks_load), 128'(0));
        check({tag, "_ks_keyin"}, ks_keyin, 128'(0));
        check({tag, "_ks_round_no"}, 128'(ks_round_no), 128'(0));
        check({tag, "_rd_key"}, rd_key, 128'(0));
        check({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        do_read(0);
        do_read(10);
        step();

        // FIPS-197 key, with ignored starts at cycles 20 and 50
        do_start(FIPS_KEY);
        goto(20);
        do_start(rand_key());
        for (int i = 0; i < 10; i++) do_read($urandom_range(0, 15));
        goto(40);
        do_read(5);
        do_read(3);
        goto(50);
        do_start(rand_key());
        for (int i = 0; i < 20; i++) do_read($urandom_range(0, 15));
        wait_done();
        issue_read(0, 1'b1, FIPS_KEY);
        issue_read(1, 1'b1, FIPS_K1);
        issue_read(10, 1'b1, FIPS_K10);
        step();
        for (int a = 0; a <= 10; a++) do_read(a);
        do_read(11);
        do_read(15);
        step();

        // Random key, asynchronous reset mid-expansion at cycle 57
        do_start(rand_key());
        for (int i = 0; i < 30; i++) do_read($urandom_range(0, 15));
        goto(55);
        do_read(2);
        step();
        #2;
        rst_n = 1'b0;
        run_active = 1'b0;
        rd_q.delete();
        done_q.delete();
        #1;
        check_all_zero("async_reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        do_read(0);

        // Restart after reset, then an immediate back-to-back start after done
        do_start(rand_key());
        for (int i = 0; i < 40; i++) do_read($urandom_range(0, 15));
        wait_done();
        for (int a = 0; a < 16; a++) do_read(a);
        do_start(rand_key());
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            else do_read($urandom_range(0, 15));
        end
        wait_done();
        for (int i = 0; i < 12; i++) do_read($urandom_range(0, 15));

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
        do_start(rand_key());
        goto(60);
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
        run_active = 1'b0;
        done_q.delete();
        check("zeroize_busy", 128'(busy), 128'(0));
        do_read(0);
        repeat (60) step();
        do_read(0);
        do_start(rand_key());
        wait_done();
        do_read(10);
`endif

        repeat (3) step();
        if (rd_q.size() != 0) check("rd_queue_drained", 128'(rd_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/round_key_store.md
# round_key_store

Expansion controller and storage for the AES-128 round keys. It takes a cipher key through a start/busy/done handshake and drives the single-round `key_schedule` stage ten times, feeding each result back as the next input. It captures all eleven 128-bit round keys (round 0 = cipher key) in a register file. It serves those keys to the round datapath through a registered read port.

## Interface
- `KS_LATENCY`, 8: clock cycles from `ks_load` falling to `ks_keyout` valid; legal range 1..15.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request expansion of `key_in`; sampled only in IDLE.
- `key_in` input [0:127]: cipher key; bit 0 is the MSB of byte 0.
- `busy` output 1: expansion in progress.
- `done` output 1: one-cycle pulse when all 11 keys are stored.
- `ks_load` output 1: drives the `key_schedule` `rst` input (high = load).
- `ks_keyin` output [0:127]: previous round key to `key_schedule`.
- `ks_round_no` output [0:3]: round index 0..9 to `key_schedule`.
- `ks_keyout` input [0:127]: next round key from `key_schedule`.
- `rd_en` input 1: read request.
- `rd_addr` input [0:3]: round key index 0..10.
- `rd_key` output [0:127]: registered read data.
- `rd_valid` output 1: `rd_key` holds a valid stored key.
- `zeroize` input 1: present only with `ROUND_KEY_STORE_ZEROIZE_EN`.

## Operation
- FSM states:
  - IDLE, then LOAD, then WAIT, then CAPTURE, then either back to LOAD (round < 9) or to DONE (round = 9). DONE returns to IDLE.
- IDLE:
  - When `start`=1, write `key_in` to entry 0, set the valid count to 1, set round r=0, and go to LOAD.
  - Otherwise hold.
- LOAD (1 cycle):
  - `ks_load`=1, `ks_keyin`=entry r, `ks_round_no`=r.
  - Clear the wait counter.
- WAIT (`KS_LATENCY` cycles):
  - `ks_load`=0; `ks_keyin` and `ks_round_no` are held stable.
  - The 4-bit counter increments each cycle; leave WAIT when it reaches `KS_LATENCY`-1.
- CAPTURE (1 cycle):
  - Write `ks_keyout` into entry r+1 and increment the valid count.
  - If r=9, go to DONE; otherwise increment r and go to LOAD.
- DONE (1 cycle): `done`=1, `busy`=0, then go to IDLE.
- `busy`=1 in LOAD, WAIT and CAPTURE only.
- `start` while not in IDLE is ignored, with no queuing.
- A new `start` in IDLE overwrites entry 0 and resets the valid count to 1; entries 1..10 become invalid until rewritten.
- Read port:
  - On `rd_en`=1: if `rd_addr` < valid count, `rd_key`=entry and `rd_valid`=1.
  - Otherwise (including `rd_addr` 11..15), `rd_key`=0 and `rd_valid`=0.
  - On `rd_en`=0, `rd_valid`=0 and `rd_key` holds its previous value.
- Read/write in the same cycle to the same entry returns the old content; `rd_valid` uses the pre-update valid count.
- Reads are permitted at any time, including during expansion.
- No arithmetic on key data; the store is a pure register file, 11 x 128 bits.

## Timing
- Reset (`rst_n`=0, any time, including mid-expansion) forces:
  - FSM to IDLE, r=0, valid count 0, all entries 0;
  - `busy`=0, `done`=0, `ks_load`=0, `ks_keyin`=0, `ks_round_no`=0, `rd_key`=0, `rd_valid`=0.
- Let `start` be sampled at edge 0:
  - LOAD for round r occupies cycle 1+r·(L+2), where L=`KS_LATENCY`.
  - Entry r+1 is written at the end of cycle (r+1)·(L+2).
  - `busy` is high in cycles 1..10·(L+2).
  - `done` is high in cycle 10·(L+2)+1, which is cycle 101 for L=8.
- Read latency: 1 cycle, from the `rd_en` edge to `rd_key`/`rd_valid`.
- `ks_*` outputs are registered and change only on LOAD entry.

## Configuration
- `ROUND_KEY_STORE_ZEROIZE_EN` defined:
  - `zeroize` port exists. `zeroize`=1 clears all entries, the valid count and r, and forces IDLE at the next edge.
  - `zeroize` has priority over `start` and CAPTURE in the same cycle. `done` is not pulsed.
- `ROUND_KEY_STORE_ZEROIZE_EN` undefined: `zeroize` port and logic are absent; keys persist until reset or the next `start`.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `start` at edge 0, L=8, real `key_schedule` model:
  - `done` at cycle 101;
  - entry 1 = `a0fafe1788542cb123a339392a6c7605`;
  - entry 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
- Reads of 0..10 after `done` return all FIPS-197 round keys with `rd_valid`=1 one cycle after `rd_en`. Reads of `rd_addr`=11 and 15 return zero with `rd_valid`=0.
- Read `rd_addr`=5 at cycle 40 (valid count 4) -> `rd_valid`=0. Read `rd_addr`=3 at cycle 40 -> `rd_valid`=1 with round key 3.
- `start` pulsed at cycles 20 and 50 -> ignored; the key set and the `done` cycle are unchanged.
- `rst_n` low at cycle 57 -> all outputs zero asynchronously. A following `start` completes normally 101 cycles later.
- With `ROUND_KEY_STORE_ZEROIZE_EN`, `zeroize` at cycle 60 -> IDLE, `busy`=0, no `done`. A subsequent read of 0 gives `rd_valid`=0.
